// File: rtl/tail_lights_timer.sv
// Dual-channel tail-light timer: a direction-sequence step timer and a hazard
// flash phase timer, each a prescaled tick counter with a sticky expiry flag.

module tail_lights_channel #(
  parameter int PRESCALE = 50000,
  parameter int PERIOD   = 250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_clear,
  input  logic       i_fast,
  output logic       o_interr,
  output logic [1:0] o_state
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int TW = $clog2(PERIOD + 1);
  localparam logic [PW-1:0] PRE_MAX  = PW'(PRESCALE - 1);
  localparam logic [TW-1:0] LIM_SLOW = TW'(PERIOD);
  localparam logic [TW-1:0] LIM_FAST = TW'(PERIOD >> 1);

  typedef enum logic [1:0] {
    ST_CLEARED = 2'd0,
    ST_RUN     = 2'd1,
    ST_EXPIRED = 2'd2
  } state_t;

  state_t        r_state, w_state_nx;
  logic [PW-1:0] r_presc, w_presc_nx;
  logic [TW-1:0] r_tick,  w_tick_nx;
  logic          r_fast,  w_fast_nx;
  logic          r_interr, w_interr_nx;
  logic          w_wrap;
  logic [TW-1:0] w_limit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_CLEARED;
      r_presc  <= '0;
      r_tick   <= '0;
      r_fast   <= 1'b0;
      r_interr <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_presc  <= w_presc_nx;
      r_tick   <= w_tick_nx;
      r_fast   <= w_fast_nx;
      r_interr <= w_interr_nx;
    end
  end

  // The edge that leaves CLEARED already counts as the first prescaler cycle,
  // so CLEARED and RUN share the counting path (counters are zero in CLEARED).
  always_comb begin
    w_state_nx  = r_state;
    w_presc_nx  = r_presc;
    w_tick_nx   = r_tick;
    w_fast_nx   = r_fast;
    w_interr_nx = r_interr;
    w_wrap      = (r_presc == PRE_MAX);
    w_limit     = r_fast ? LIM_FAST : LIM_SLOW;
    if (i_clear) begin
      w_state_nx  = ST_CLEARED;
      w_presc_nx  = '0;
      w_tick_nx   = '0;
      w_fast_nx   = i_fast;
      w_interr_nx = 1'b0;
    end else begin
      case (r_state)
        ST_CLEARED, ST_RUN: begin
          w_state_nx = ST_RUN;
          if (w_wrap) begin
            w_presc_nx = '0;
            w_tick_nx  = r_tick + TW'(1);
            if (r_tick + TW'(1) == w_limit) begin
              w_state_nx  = ST_EXPIRED;
              w_interr_nx = 1'b1;
            end
          end else begin
            w_presc_nx = r_presc + PW'(1);
          end
        end
        ST_EXPIRED: begin
          w_state_nx  = ST_EXPIRED;
          w_interr_nx = 1'b1;
        end
        default: begin
          w_state_nx  = ST_CLEARED;
          w_presc_nx  = '0;
          w_tick_nx   = '0;
          w_interr_nx = 1'b0;
        end
      endcase
    end
  end

  assign o_interr = r_interr;
  assign o_state  = r_state;

endmodule

module tail_lights_timer #(
  parameter int PRESCALE   = 50000,
  parameter int DIR_PERIOD = 250,
  parameter int HAZ_PERIOD = 500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear_timer_dir,
  input  logic       clear_timer_haz,
  input  logic       fast,
  output logic       interr_dir,
  output logic       interr_haz,
  output logic [1:0] o_dbg_state_dir,
  output logic [1:0] o_dbg_state_haz
);

  tail_lights_channel #(
    .PRESCALE (PRESCALE),
    .PERIOD   (DIR_PERIOD)
  ) u_dir (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (clear_timer_dir),
    .i_fast   (fast),
    .o_interr (interr_dir),
    .o_state  (o_dbg_state_dir)
  );

  tail_lights_channel #(
    .PRESCALE (PRESCALE),
    .PERIOD   (HAZ_PERIOD)
  ) u_haz (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (clear_timer_haz),
    .i_fast   (fast),
    .o_interr (interr_haz),
    .o_state  (o_dbg_state_haz)
  );

endmodule

// File: doc/tail_lights_timer.md
TAIL_LIGHTS_TIMER -- requirements
Module: tail_lights_timer

Interface
REQ-001 SHALL provide parameter PRESCALE, default 50000; clock cycles per timer tick (1 ms at 50 MHz), minimum 1.
REQ-002 SHALL provide parameter DIR_PERIOD, default 250; ticks per direction-sequence step, minimum 2.
REQ-003 SHALL provide parameter HAZ_PERIOD, default 500; ticks per hazard on/off phase, minimum 2.
REQ-004 SHALL have port clk, input, 1; system clock, all state on rising edge.
REQ-005 SHALL have port reset, input, 1; asynchronous, active-high reset.
REQ-006 SHALL have port clear_timer_dir, input, 1; holds the direction channel at zero while high.
REQ-007 SHALL have port clear_timer_haz, input, 1; holds the hazard channel at zero while high.
REQ-008 SHALL have port fast, input, 1; halves both periods (bulb-fault flash rate), sampled per channel while that channel's clear is high.
REQ-009 SHALL have port interr_dir, output, 1; direction step expired, registered, sticky.
REQ-010 SHALL have port interr_haz, output, 1; hazard phase expired, registered, sticky.

Function
REQ-011 SHALL implement two independent, identical channels (dir, haz), each with its own prescaler counter, tick counter, latched fast flag and FSM; no shared state between channels.
REQ-012 Each channel FSM SHALL have states CLEARED, RUN, EXPIRED.
REQ-013 CLEARED: prescaler=0, tick counter=0, interr=0, latched fast flag <= fast each edge; on an edge with clear=0 -> RUN.
REQ-014 RUN: prescaler counts 0..PRESCALE-1 and wraps to 0; tick counter increments on each wrap; on the edge where the tick counter would reach LIMIT -> EXPIRED.
REQ-015 LIMIT SHALL be PERIOD when latched fast=0 and PERIOD>>1 (floor) when latched fast=1; fast changes during RUN/EXPIRED SHALL have no effect.
REQ-016 Latency: interr SHALL read 1 exactly PRESCALE*LIMIT clock edges after the first edge sampling clear=0 (edge counted as 1); dir defaults 12,500,000 cycles, haz 25,000,000.
REQ-017 EXPIRED: interr=1 and held, counters frozen, until an edge samples clear=1.
REQ-018 Any edge sampling clear=1 in any state SHALL -> CLEARED with interr=0 on that edge; clear has priority over expiry on the same edge.
REQ-019 A one-cycle clear pulse SHALL fully restart the channel; the next period is timed from the first edge sampling clear=0.
REQ-020 If clear is never asserted after reset, the channel SHALL run from reset release and expire normally (free-running power-up).
REQ-021 Counter widths SHALL be clog2-sized to hold PRESCALE-1 and PERIOD without overflow; no wrap of the tick counter is permitted.
REQ-022 interr_dir and interr_haz SHALL be driven directly from flip-flops (no combinational path from any input).

Reset
REQ-023 On reset=1 both channels SHALL enter CLEARED asynchronously: counters 0, latched fast 0, interr_dir=0, interr_haz=0.
REQ-024 Reset mid-RUN or in EXPIRED SHALL discard all progress; timing restarts per REQ-016 after reset release.

Verification (PRESCALE=4, DIR_PERIOD=3, HAZ_PERIOD=5)
REQ-025 Reset, clear_dir 1 then 0 at edge E -> interr_dir rises at edge E+11 (12th edge), stays 1 for 20 further cycles with clear_dir=0.
REQ-026 interr_dir=1, pulse clear_dir for one cycle -> interr_dir 0 on that edge, rises again exactly 12 edges after first clear=0 edge.
REQ-027 fast=1 during clear_haz, then fast=0 with clear_haz released -> interr_haz after 8 edges (LIMIT=2); fast toggled mid-run has no effect.
REQ-028 clear_dir asserted on the exact edge expiry would occur -> interr_dir stays 0, channel CLEARED.
REQ-029 Both channels running, clear_haz pulsed at random points -> interr_dir timing unaffected (12 edges), haz channel independent.
REQ-030 Assert reset asynchronously mid-RUN and during EXPIRED -> both interr outputs 0 immediately, no residual count after release.
